// File: rtl/async_queue_sink_pkg.sv
// Shared definitions for the consumer side of the clock-crossing queue:
// index helpers (clog2, Gray/binary conversion) and index reset value.
package async_queue_sink_pkg;

  localparam int IDX_WORD_W = 32;
  typedef logic [IDX_WORD_W-1:0] idx_word_t;

  // Reset value of every index register (binary and Gray agree at zero).
  localparam idx_word_t IDX_RST = '0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic idx_word_t bin2gray(input idx_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic idx_word_t gray2bin(input idx_word_t g);
    idx_word_t b;
    b[IDX_WORD_W-1] = g[IDX_WORD_W-1];
    for (int i = IDX_WORD_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_shift_reg_vec.sv
// SYNC-deep chain of W-bit registers used to bring an asynchronous
// Gray-coded vector into the local clock domain. Stages are plain flops
// with nothing between them so each bit resolves metastability cleanly.
module sync_shift_reg_vec #(
  parameter int W    = 1,
  parameter int SYNC = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_q [SYNC];
  logic [W-1:0] sync_d [SYNC];

  // Each stage takes the previous one; stage 0 takes the async input.
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < SYNC; i++) sync_d[i] = sync_q[i-1];
  end

  // Synchronizer stages, cleared immediately on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign q = sync_q[SYNC-1];

endmodule

// File: rtl/async_queue_sink.sv
// Dequeue side of the clock-crossing queue. Synchronizes the producer's
// Gray write index, reads entries out of the producer-held storage,
// presents them on a registered ready/valid port and publishes its own
// Gray read index back to the producer.
//
// Handshake: an entry transfers on a rising edge where io_deq_valid and
// io_deq_ready are both high. While io_deq_valid is high and ready is low,
// io_deq_bits and io_deq_valid hold. Every output comes from a flop.
module async_queue_sink
  import async_queue_sink_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 8,
  parameter int  SYNC  = 3,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DEPTH*WIDTH-1:0] io_async_mem,
  input  logic [AW:0]            io_async_widx,
  output logic [AW:0]            io_async_ridx,
  output logic                   io_deq_valid,
  input  logic                   io_deq_ready,
  output logic [WIDTH-1:0]       io_deq_bits
);

  localparam int IW = AW + 1;

  logic [IW-1:0]    widx_s;
  logic [IW-1:0]    ridx_bin_q, ridx_bin_d;
  logic [IW-1:0]    ridx_gray_q, ridx_gray_d;
  logic [IW-1:0]    ridx_bin_inc, ridx_gray_inc;
  logic             deq_valid_q, deq_valid_d;
  logic [WIDTH-1:0] deq_bits_q, deq_bits_d;
  logic             pending, load;
  logic [WIDTH-1:0] entries [DEPTH];

  sync_shift_reg_vec #(
    .W    (IW),
    .SYNC (SYNC)
  ) u_widx_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_async_widx),
    .q     (widx_s)
  );

  // Split the flat producer storage into addressable entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries[i] = io_async_mem[i*WIDTH +: WIDTH];
  end

  // Next-state: load whenever data is pending and the output slot is free
  // or being emptied this cycle; otherwise drain on a handshake.
  always_comb begin
    ridx_bin_inc  = ridx_bin_q + IW'(1);
    ridx_gray_inc = IW'(bin2gray(IDX_WORD_W'(ridx_bin_inc)));
    pending       = (ridx_gray_q != widx_s);
    load          = pending && (!deq_valid_q || io_deq_ready);

    ridx_bin_d  = ridx_bin_q;
    ridx_gray_d = ridx_gray_q;
    deq_valid_d = deq_valid_q;
    deq_bits_d  = deq_bits_q;

    if (load) begin
      deq_bits_d  = entries[ridx_bin_q[AW-1:0]];
      deq_valid_d = 1'b1;
      ridx_bin_d  = ridx_bin_inc;
      ridx_gray_d = ridx_gray_inc;
    end else if (io_deq_ready) begin
      deq_valid_d = 1'b0;
    end
  end

  // Read pointer and output register; reset discards any held entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ridx_bin_q  <= IW'(IDX_RST);
      ridx_gray_q <= IW'(IDX_RST);
      deq_valid_q <= 1'b0;
      deq_bits_q  <= '0;
    end else begin
      ridx_bin_q  <= ridx_bin_d;
      ridx_gray_q <= ridx_gray_d;
      deq_valid_q <= deq_valid_d;
      deq_bits_q  <= deq_bits_d;
    end
  end

  assign io_async_ridx = ridx_gray_q;
  assign io_deq_valid  = deq_valid_q;
  assign io_deq_bits   = deq_bits_q;

endmodule

// File: tb/tb_async_queue_sink.sv
// Bench for async_queue_sink: a producer model writes entries into the
// storage array and advances a Gray write index; a monitor pops the
// expected queue on every accepted beat.
module tb_async_queue_sink;
  import async_queue_sink_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int AW    = 3;
  localparam int IW    = AW + 1;

  logic                   clock;
  logic                   reset;
  logic [DEPTH*WIDTH-1:0] io_async_mem;
  logic [IW-1:0]          io_async_widx;
  logic [IW-1:0]          io_async_ridx;
  logic                   io_deq_valid;
  logic                   io_deq_ready;
  logic [WIDTH-1:0]       io_deq_bits;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int n_checks;
  int n_errors;
  int wbin;

  async_queue_sink #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SYNC  (SYNC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_async_mem  (io_async_mem),
    .io_async_widx (io_async_widx),
    .io_async_ridx (io_async_ridx),
    .io_deq_valid  (io_deq_valid),
    .io_deq_ready  (io_deq_ready),
    .io_deq_bits   (io_deq_bits)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) io_async_mem[i*WIDTH +: WIDTH] = mem[i];
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] gray_of(input int b);
    idx_word_t t;
    t = bin2gray(idx_word_t'(b));
    return t[IW-1:0];
  endfunction

  function automatic int bin_of(input logic [IW-1:0] g);
    idx_word_t t;
    t = gray2bin(idx_word_t'(g));
    return int'(t);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic sample_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push_entry(input logic [WIDTH-1:0] d);
    mem[wbin % DEPTH] = d;
    exp_q.push_back(d);
    wbin = (wbin + 1) % (2 * DEPTH);
  endtask

  task automatic publish();
    io_async_widx = gray_of(wbin);
  endtask

  task automatic reset_dut(input bit chk);
    drive_edge();
    reset = 1'b0;
    #1;
    if (chk) begin
      check("rst_valid", WIDTH'(io_deq_valid), 0);
      check("rst_bits", io_deq_bits, 0);
      check("rst_ridx", WIDTH'(io_async_ridx), 0);
    end
    exp_q.delete();
    wbin = 0;
    publish();
    io_deq_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int max, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clock);
      if (io_deq_valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: valid not seen within %0d cycles, got 0 expected 1", name, max);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [IW-1:0] prev_ridx;
    logic          prev_rst;
    prev_ridx = '0;
    prev_rst  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && prev_rst && (io_async_ridx != prev_ridx)) begin
        n_checks++;
        if ($countones(io_async_ridx ^ prev_ridx) != 1) begin
          n_errors++;
          $display("FAIL ridx_gray_step: got 0x%0h after 0x%0h expected one-bit change",
                   io_async_ridx, prev_ridx);
        end
      end
      if (reset && io_deq_valid && io_deq_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL deq_unexpected: got 0x%0h expected no beat", io_deq_bits);
        end else begin
          check("deq_bits", io_deq_bits, exp_q.pop_front());
        end
      end
      prev_ridx = io_async_ridx;
      prev_rst  = reset;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] first;
    n_checks     = 0;
    n_errors     = 0;
    wbin         = 0;
    reset        = 1'b1;
    io_deq_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    publish();

    // Reset: outputs clear without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("init_valid", WIDTH'(io_deq_valid), 0);
    check("init_bits", io_deq_bits, 0);
    check("init_ridx", WIDTH'(io_async_ridx), 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    // Single entry: valid rises on the SYNC+1-th edge after widx changes.
    drive_edge();
    push_entry(32'hA5A5_0001);
    publish();
    for (int k = 1; k <= SYNC; k++) begin
      sample_edge();
      check("single_early_valid", WIDTH'(io_deq_valid), 0);
    end
    sample_edge();
    check("single_valid", WIDTH'(io_deq_valid), 1);
    check("single_bits", io_deq_bits, 32'hA5A5_0001);
    check("single_ridx", WIDTH'(io_async_ridx), 1);
    drive_edge();
    io_deq_ready = 1'b1;
    sample_edge();
    check("single_drain", WIDTH'(io_deq_valid), 0);

    // Back-to-back: 8 beats without bubbles, final ridx Gray(8).
    reset_dut(1'b0);
    drive_edge();
    io_deq_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_entry(WIDTH'(32'h10 + i));
    publish();
    wait_valid(10, "b2b_start");
    for (int i = 0; i < DEPTH; i++) begin
      check("b2b_valid", WIDTH'(io_deq_valid), 1);
      check("b2b_bits", io_deq_bits, WIDTH'(32'h10 + i));
      if (i < DEPTH - 1) @(negedge clock);
    end
    @(negedge clock);
    check("b2b_drain", WIDTH'(io_deq_valid), 0);
    check("b2b_ridx", WIDTH'(io_async_ridx), 32'hC);

    // Backpressure: 3 pending, ready low, output stable, ridx advanced once.
    drive_edge();
    io_deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_entry($urandom);
    first = exp_q[0];
    publish();
    wait_valid(10, "bp_start");
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", WIDTH'(io_deq_valid), 1);
      check("bp_bits", io_deq_bits, first);
      check("bp_ridx", WIDTH'(io_async_ridx), WIDTH'(gray_of(9)));
      @(negedge clock);
    end

    // Reset mid-transfer while an entry is held.
    reset_dut(1'b1);

    // Randomized traffic with wrap-around; producer respects full.
    for (int cyc = 0; cyc < 500; cyc++) begin
      drive_edge();
      io_deq_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 &&
          ((wbin - bin_of(io_async_ridx)) & (2 * DEPTH - 1)) < DEPTH) begin
        push_entry($urandom);
      end
      publish();
    end
    drive_edge();
    io_deq_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clock);
    check("rand_drained", WIDTH'(exp_q.size()), 0);
    @(negedge clock);
    check("rand_valid_low", WIDTH'(io_deq_valid), 0);
    check("rand_ridx", WIDTH'(io_async_ridx), WIDTH'(gray_of(wbin)));

    // Empty hold: ready toggles, nothing moves.
    for (int i = 0; i < 10; i++) begin
      drive_edge();
      io_deq_ready = ~io_deq_ready;
      @(negedge clock);
      check("empty_valid", WIDTH'(io_deq_valid), 0);
      check("empty_ridx", WIDTH'(io_async_ridx), WIDTH'(gray_of(wbin)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
